// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer: operand modes,
// universal-shift-register select codes and the sequencer state encoding.
package shift_seq_pkg;

  // Shift flavour latched on an accepted request; encoding 11 folds to logical.
  typedef enum logic [1:0] {
    MODE_LOG   = 2'b00,
    MODE_ARITH = 2'b01,
    MODE_ROT   = 2'b10
  } mode_e;

  // Select codes understood by the downstream MC10141-style register chain.
  localparam logic [1:0] USR_LOAD = 2'b00;
  localparam logic [1:0] USR_SHR  = 2'b01;  // toward higher index, S0 fills bit 0
  localparam logic [1:0] USR_SHL  = 2'b10;  // toward lower index, S3 fills bit WIDTH-1
  localparam logic [1:0] USR_HOLD = 2'b11;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_FIN   = 2'b10
  } state_e;

  // Map the raw MODE input onto the three supported modes.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   decode_mode = MODE_ARITH;
      2'b10:   decode_mode = MODE_ROT;
      default: decode_mode = MODE_LOG;
    endcase
  endfunction

endpackage

// File: rtl/shift_sequencer_count.sv
// Loadable down-counter holding the number of shifts still to perform.
// Decrementing stops at zero so the count can never wrap.
module shift_count_down #(
  parameter int CNTW = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            i_load,
  input  logic            i_dec,
  input  logic [CNTW-1:0] i_d,
  output logic [CNTW-1:0] o_q,
  output logic            o_is_one,
  output logic            o_is_zero
);

  logic [CNTW-1:0] r_cnt;

  // Load has priority over decrement; decrement is blocked at zero.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_d;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_q       = r_cnt;
  assign o_is_one  = (r_cnt == {{(CNTW-1){1'b0}}, 1'b1});
  assign o_is_zero = (r_cnt == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Control stage for a chain of 4-bit universal shift registers. Accepts a
// one-shot request, steers the chain's SEL/serial inputs for COUNT cycles and
// keeps a shadow copy of the chain contents (bit 0 = MSB) in DOUT.
//
// Handshake: START is a request strobe honoured only while BUSY is low
// (IDLE); it is consumed on the rising edge where START=1 and BUSY=0. BUSY
// stays high from the next cycle through the single DONE cycle; any START
// seen while BUSY is dropped with no side effects.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int CNTW  = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [0:WIDTH-1] DIN,
  input  logic [CNTW-1:0]  COUNT,
  input  logic             DIR,
  input  logic [1:0]       MODE,
  output logic [1:0]       SEL,
  output logic             S0_OUT,
  output logic             S3_OUT,
  output logic [0:WIDTH-1] DOUT,
  output logic [CNTW-1:0]  CNT_LEFT,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       DBG_STATE
);

  state_e           r_state;
  state_e           w_next;
  logic             r_dir;
  mode_e            r_mode;
  logic [0:WIDTH-1] r_dout;
  logic             w_load;
  logic             w_dec;
  logic             w_s0;
  logic             w_s3;
  logic             w_is_one;
  logic             w_is_zero;

  shift_count_down #(.CNTW(CNTW)) u_cnt (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_load    (w_load),
    .i_dec     (w_dec),
    .i_d       (COUNT),
    .o_q       (CNT_LEFT),
    .o_is_one  (w_is_one),
    .o_is_zero (w_is_zero)
  );

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, chain select and completion strobe.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    SEL    = USR_HOLD;
    DONE   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          SEL    = USR_LOAD;
          w_load = 1'b1;
          w_next = (COUNT != '0) ? ST_SHIFT : ST_FIN;
        end
      end
      ST_SHIFT: begin
        SEL   = r_dir ? USR_SHL : USR_SHR;
        w_dec = !w_is_zero;
        // The zero check only guards against an impossible entry with count 0.
        if (w_is_one || w_is_zero) begin
          w_next = ST_FIN;
        end
      end
      ST_FIN: begin
        DONE   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Serial fill bits, only live while shifting.
  always_comb begin
    w_s0 = 1'b0;
    w_s3 = 1'b0;
    if (r_state == ST_SHIFT) begin
      if (!r_dir) begin
        case (r_mode)
          MODE_ARITH: w_s0 = r_dout[0];
          MODE_ROT:   w_s0 = r_dout[WIDTH-1];
          default:    w_s0 = 1'b0;
        endcase
      end else if (r_mode == MODE_ROT) begin
        w_s3 = r_dout[0];
      end
    end
  end

  // Shadow register and latched request controls, mirroring the chain.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_dout <= '0;
      r_dir  <= 1'b0;
      r_mode <= MODE_LOG;
    end else if (w_load) begin
      r_dout <= DIN;
      r_dir  <= DIR;
      r_mode <= decode_mode(MODE);
    end else if (r_state == ST_SHIFT) begin
      if (!r_dir) begin
        r_dout <= {w_s0, r_dout[0:WIDTH-2]};
      end else begin
        r_dout <= {r_dout[1:WIDTH-1], w_s3};
      end
    end
  end

  assign S0_OUT    = w_s0;
  assign S3_OUT    = w_s3;
  assign DOUT      = r_dout;
  assign BUSY      = (r_state != ST_IDLE);
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized bench for shift_sequencer. Expected results come
// from an arithmetic model of the shift rules (numeric value, MSB = bit 0).
module tb_shift_sequencer;

  localparam int W = 36;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  din;
  logic [5:0]    count;
  logic          dir;
  logic [1:0]    mode;
  logic [1:0]    sel;
  logic          s0_out;
  logic          s3_out;
  logic [W-1:0]  dout;
  logic [5:0]    cnt_left;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.WIDTH(W), .CNTW(6)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .START     (start),
    .DIN       (din),
    .COUNT     (count),
    .DIR       (dir),
    .MODE      (mode),
    .SEL       (sel),
    .S0_OUT    (s0_out),
    .S3_OUT    (s3_out),
    .DOUT      (dout),
    .CNT_LEFT  (cnt_left),
    .BUSY      (busy),
    .DONE      (done),
    .DBG_STATE (dbg_state)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result of applying c single-bit shifts to v. dir 0 moves bits toward
  // the LSB (numeric right shift), dir 1 toward the MSB (numeric left shift).
  function automatic logic [W-1:0] model(input logic [W-1:0] v, input int c,
                                         input logic d, input logic [1:0] m);
    logic [W-1:0] r;
    int rr;
    rr = c % W;
    if (!d) begin
      if (m == 2'b10)      r = (rr == 0) ? v : ((v >> rr) | (v << (W - rr)));
      else if (m == 2'b01) r = (c >= W) ? {W{v[W-1]}} : W'($signed(v) >>> c);
      else                 r = (c >= W) ? '0 : (v >> c);
    end else begin
      if (m == 2'b10)      r = (rr == 0) ? v : ((v << rr) | (v >> (W - rr)));
      else                 r = (c >= W) ? '0 : (v << c);
    end
    return r;
  endfunction

  task automatic drive_junk();
    start = 1'($urandom_range(0, 1));
    din   = {4'($urandom), 32'($urandom)};
    count = 6'($urandom);
    dir   = 1'($urandom);
    mode  = 2'($urandom);
  endtask

  // One complete request, checked every cycle from START to return to IDLE.
  task automatic run_op(input logic [W-1:0] v, input int c, input logic d,
                        input logic [1:0] m, input bit junk);
    logic [W-1:0] cur;
    logic         e_s0;
    logic         e_s3;
    @(negedge clk);
    start = 1'b1; din = v; count = 6'(c); dir = d; mode = m;
    #1;
    check("idle_sel_load", sel, 2'b00);
    check("idle_busy", busy, 1'b0);
    @(negedge clk);
    for (int k = 0; k < c; k++) begin
      if (junk) drive_junk(); else start = 1'b0;
      cur  = model(v, k, d, m);
      e_s0 = 1'b0;
      e_s3 = 1'b0;
      if (!d && m == 2'b01) e_s0 = cur[W-1];
      if (!d && m == 2'b10) e_s0 = cur[0];
      if (d && m == 2'b10)  e_s3 = cur[W-1];
      #1;
      check("shift_sel", sel, d ? 2'b10 : 2'b01);
      check("shift_busy", busy, 1'b1);
      check("shift_done", done, 1'b0);
      check("shift_cnt", cnt_left, 64'(c - k));
      check("shift_dout", dout, cur);
      check("shift_s0", s0_out, e_s0);
      check("shift_s3", s3_out, e_s3);
      @(negedge clk);
    end
    if (junk) drive_junk(); else start = 1'b0;
    cur = model(v, c, d, m);
    #1;
    check("fin_done", done, 1'b1);
    check("fin_busy", busy, 1'b1);
    check("fin_sel", sel, 2'b11);
    check("fin_cnt", cnt_left, 0);
    check("fin_dout", dout, cur);
    check("fin_serial", {s0_out, s3_out}, 2'b00);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("post_done", done, 1'b0);
    check("post_busy", busy, 1'b0);
    check("post_sel", sel, 2'b11);
    check("post_dout", dout, cur);
    check("post_cnt", cnt_left, 0);
  endtask

  initial begin
    logic [W-1:0] v;
    rst = 1'b1; start = 1'b0; din = '0; count = '0; dir = 1'b0; mode = 2'b00;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", dout, 0);
    check("rst_cnt", cnt_left, 0);
    check("rst_sel", sel, 2'b11);
    check("rst_serial", {s0_out, s3_out}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_op(36'o000000_000017, 2, 1'b0, 2'b00, 1'b0);
    check("t1_result", dout, 36'o000000_000003);
    run_op(36'o400000_000000, 3, 1'b0, 2'b01, 1'b0);
    check("t2_result", dout, 36'o740000_000000);
    run_op(36'o400000_000001, 1, 1'b1, 2'b10, 1'b0);
    check("t3_result", dout, 36'o000000_000003);
    run_op(36'o123456_701234, 0, 1'b0, 2'b00, 1'b0);
    check("t4_result", dout, 36'o123456_701234);
    run_op({W{1'b1}}, 40, 1'b1, 2'b00, 1'b0);
    check("t5_log_result", dout, 0);
    run_op({W{1'b1}}, 36, 1'b1, 2'b10, 1'b0);
    check("t5_rot_result", dout, {W{1'b1}});
    run_op(36'o400000_000000, 63, 1'b0, 2'b01, 1'b0);
    check("arith_sat", dout, {W{1'b1}});
    run_op(36'o000000_000005, 2, 1'b0, 2'b11, 1'b0);
    check("mode11_logical", dout, 36'o000000_000001);

    // Randomized requests with busy-time input churn.
    for (int n = 0; n < 30; n++) begin
      run_op({4'($urandom), 32'($urandom)}, $urandom_range(0, 63),
             1'($urandom), 2'($urandom), 1'b1);
    end

    // Ignored START mid-shift, then reset mid-shift.
    v = {4'($urandom), 32'($urandom)} | 36'o400000_000000;
    @(negedge clk);
    start = 1'b1; din = v; count = 6'd10; dir = 1'b0; mode = 2'b01;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      start = (k == 3);
      if (k == 3) begin din = ~v; count = 6'd1; dir = 1'b1; mode = 2'b10; end
      #1;
      check("t6_cnt", cnt_left, 64'(10 - k));
      check("t6_dout", dout, model(v, k, 1'b0, 2'b01));
      check("t6_busy", busy, 1'b1);
      if (k < 5) @(negedge clk);
    end
    start = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_dout", dout, 0);
    check("t6_rst_cnt", cnt_left, 0);
    check("t6_rst_sel", sel, 2'b11);
    check("t6_rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("t6_no_done", done, 1'b0);
      check("t6_idle_busy", busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
